// File: rtl/imsic_msi_sender.sv
// Queues decoded MSI writes and replays each one as a wide, stable-data level
// pulse so the IMSIC receive stage can capture it safely across clock domains.
module imsic_msi_sender #(
    parameter int NR_INTP_FILES    = 7,
    parameter int NR_HARTS         = 1,
    parameter int NR_SRC           = 256,
    parameter int FIFO_DEPTH       = 4,
    parameter int VLD_HIGH_CYCLES  = 8,
    parameter int INFO_HOLD_CYCLES = 8,
    localparam int NR_HARTS_WIDTH  = (NR_HARTS == 1) ? 1 : $clog2(NR_HARTS),
    localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + $clog2(NR_INTP_FILES)
                                     + $clog2(NR_SRC),
    localparam int CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst,
    input  logic [MSI_INFO_WIDTH-1:0] i_msi_info,
    input  logic                      i_msi_info_vld,
    output logic                      o_msi_info_rdy,
    output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
    output logic                      o_msi_info_vld,
    output logic [CNT_WIDTH-1:0]      o_fifo_cnt,
    output logic                      o_busy
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int TMR_MAX   = (VLD_HIGH_CYCLES > INFO_HOLD_CYCLES) ?
                               VLD_HIGH_CYCLES : INFO_HOLD_CYCLES;
    localparam int TMR_WIDTH = $clog2(TMR_MAX) + 1;

    localparam logic [CNT_WIDTH-1:0] FULL      = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [TMR_WIDTH-1:0] HIGH_LOAD = TMR_WIDTH'(VLD_HIGH_CYCLES - 1);
    localparam logic [TMR_WIDTH-1:0] HOLD_LOAD = TMR_WIDTH'(INFO_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t                    state;
    logic [MSI_INFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]      wr_ptr;
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]      fifo_cnt;
    logic [TMR_WIDTH-1:0]      cnt;
    logic                      push;
    logic                      pop;

    assign o_msi_info_rdy = ~axi_rst & (fifo_cnt != FULL);
    assign push           = i_msi_info_vld & o_msi_info_rdy;
    assign pop            = (state == IDLE) & (fifo_cnt != '0);
    assign o_fifo_cnt     = fifo_cnt;
    assign o_busy         = (state != IDLE) | (fifo_cnt != '0);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge axi_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_msi_info;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Data is only reloaded from IDLE, so it stays frozen through the hold gap.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            o_msi_info     <= '0;
            o_msi_info_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        o_msi_info     <= mem[rd_ptr];
                        o_msi_info_vld <= 1'b1;
                        cnt            <= HIGH_LOAD;
                        state          <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        o_msi_info_vld <= 1'b0;
                        cnt            <= HOLD_LOAD;
                        state          <= LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imsic_msi_sender.sv
// Randomized bench for imsic_msi_sender: a scoreboard queue tracks delivery
// order, pulse widths, gaps and queue occupancy; scenario tasks check timing.
module tb_imsic_msi_sender;

    localparam int W = 12;

    logic         axi_clk = 1'b0;
    logic         axi_rst = 1'b1;
    logic [W-1:0] i_msi_info = '0;
    logic         i_msi_info_vld = 1'b0;
    logic         o_msi_info_rdy;
    logic [W-1:0] o_msi_info;
    logic         o_msi_info_vld;
    logic [2:0]   o_fifo_cnt;
    logic         o_busy;

    logic [W-1:0] m_info = '0;
    logic         m_vld = 1'b0;
    logic         m_rdy;
    logic [W-1:0] m_out;
    logic         m_out_vld;
    logic [2:0]   m_cnt;
    logic         m_busy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 axi_clk = ~axi_clk;

    imsic_msi_sender dut (
        .axi_clk       (axi_clk),
        .axi_rst       (axi_rst),
        .i_msi_info    (i_msi_info),
        .i_msi_info_vld(i_msi_info_vld),
        .o_msi_info_rdy(o_msi_info_rdy),
        .o_msi_info    (o_msi_info),
        .o_msi_info_vld(o_msi_info_vld),
        .o_fifo_cnt    (o_fifo_cnt),
        .o_busy        (o_busy)
    );

    imsic_msi_sender #(
        .VLD_HIGH_CYCLES (1),
        .INFO_HOLD_CYCLES(1)
    ) dut_min (
        .axi_clk       (axi_clk),
        .axi_rst       (axi_rst),
        .i_msi_info    (m_info),
        .i_msi_info_vld(m_vld),
        .o_msi_info_rdy(m_rdy),
        .o_msi_info    (m_out),
        .o_msi_info_vld(m_out_vld),
        .o_fifo_cnt    (m_cnt),
        .o_busy        (m_busy)
    );

    // Scoreboard for the default-parameter instance
    logic [W-1:0] expq[$];
    int           pushed = 0;
    int           started = 0;
    int           hi_run = 0;
    int           lo_run = 0;
    bit           have_pulse = 0;
    bit           prev_vld = 0;
    bit           hs_prev = 0;
    bit           rst_prev = 0;
    bit           mon_en = 0;
    logic [W-1:0] hs_data = '0;
    logic [W-1:0] last_info = '0;

    always @(negedge axi_clk) begin
        if (mon_en) begin
            if (rst_prev) begin
                expq.delete();
                pushed = 0;
                started = 0;
                have_pulse = 0;
                hi_run = 0;
                lo_run = 0;
                n_checks++;
                if (o_msi_info_vld !== 1'b0 || o_msi_info !== '0 ||
                    o_fifo_cnt !== 3'd0) begin
                    n_fail++;
                    $display("FAIL reset_clear: vld=%b info=%h cnt=%0d want 0/0/0",
                             o_msi_info_vld, o_msi_info, o_fifo_cnt);
                end
            end else begin
                if (hs_prev) begin
                    expq.push_back(hs_data);
                    pushed++;
                end
                if (o_msi_info_vld && !prev_vld) begin
                    n_checks++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL order: pulse info=%h with empty queue",
                                 o_msi_info);
                    end else begin
                        logic [W-1:0] e;
                        e = expq.pop_front();
                        if (o_msi_info !== e) begin
                            n_fail++;
                            $display("FAIL order: got %h want %h", o_msi_info, e);
                        end
                    end
                    started++;
                    if (have_pulse) begin
                        n_checks++;
                        if (lo_run < 9) begin
                            n_fail++;
                            $display("FAIL gap: low %0d cycles want >=9", lo_run);
                        end
                    end
                    have_pulse = 1;
                    hi_run = 1;
                end else begin
                    n_checks++;
                    if (o_msi_info !== last_info) begin
                        n_fail++;
                        $display("FAIL info_stable: got %h want %h",
                                 o_msi_info, last_info);
                    end
                    if (o_msi_info_vld) begin
                        hi_run++;
                    end else if (prev_vld) begin
                        n_checks++;
                        if (hi_run != 8) begin
                            n_fail++;
                            $display("FAIL width: high %0d cycles want 8", hi_run);
                        end
                        lo_run = 1;
                    end else begin
                        lo_run++;
                    end
                end
                n_checks++;
                if (int'(o_fifo_cnt) != pushed - started || o_fifo_cnt > 3'd4) begin
                    n_fail++;
                    $display("FAIL count: got %0d want %0d",
                             o_fifo_cnt, pushed - started);
                end
            end
            n_checks++;
            if (o_msi_info_rdy !== (!axi_rst && o_fifo_cnt != 3'd4)) begin
                n_fail++;
                $display("FAIL rdy: got %b cnt=%0d rst=%b",
                         o_msi_info_rdy, o_fifo_cnt, axi_rst);
            end
            prev_vld = o_msi_info_vld;
            last_info = o_msi_info;
        end
        hs_prev = i_msi_info_vld & o_msi_info_rdy;
        hs_data = i_msi_info;
        rst_prev = axi_rst;
    end

    task automatic push(input logic [W-1:0] d);
        int t = 0;
        i_msi_info_vld = 1'b1;
        i_msi_info = d;
        @(negedge axi_clk);
        while (!o_msi_info_rdy && t < 200) begin
            @(negedge axi_clk);
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL push_timeout: rdy=%b after %0d cycles want 1",
                     o_msi_info_rdy, t);
        end
        @(posedge axi_clk);
        #1;
        i_msi_info_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge axi_clk);
        while ((o_busy || o_msi_info_vld) && t < 1000) begin
            @(negedge axi_clk);
            t++;
        end
        n_checks++;
        if (t >= 1000) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b want 0", o_busy);
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        n_checks++;
        if (o_msi_info_vld !== 1'b0 || o_msi_info !== '0 || o_fifo_cnt !== 3'd0 ||
            o_busy !== 1'b0 || o_msi_info_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: vld=%b info=%h cnt=%0d busy=%b rdy=%b want 0",
                     o_msi_info_vld, o_msi_info, o_fifo_cnt, o_busy, o_msi_info_rdy);
        end
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        mon_en = 1;
        @(negedge axi_clk);
        n_checks++;
        if (o_msi_info_rdy !== 1'b1 || m_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rdy_after_reset: got %b/%b want 1/1",
                     o_msi_info_rdy, m_rdy);
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic test_single();
        wait_idle();
        i_msi_info_vld = 1'b1;
        i_msi_info = 12'h0A5;
        @(negedge axi_clk);
        n_checks++;
        if (o_fifo_cnt !== 3'd0 || o_busy !== 1'b0 || o_msi_info_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c0: cnt=%0d busy=%b vld=%b want 0/0/0",
                     o_fifo_cnt, o_busy, o_msi_info_vld);
        end
        for (int k = 1; k <= 18; k++) begin
            @(posedge axi_clk);
            #1;
            i_msi_info_vld = 1'b0;
            @(negedge axi_clk);
            n_checks++;
            if (o_fifo_cnt !== ((k == 1) ? 3'd1 : 3'd0) ||
                o_msi_info_vld !== (k >= 2 && k <= 9) ||
                o_busy !== (k <= 17) ||
                (k >= 2 && o_msi_info !== 12'h0A5)) begin
                n_fail++;
                $display("FAIL single_c%0d: cnt=%0d vld=%b busy=%b info=%h",
                         k, o_fifo_cnt, o_msi_info_vld, o_busy, o_msi_info);
            end
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d[6];
        wait_idle();
        for (int i = 0; i < 6; i++) d[i] = W'($urandom);
        for (int i = 0; i < 5; i++) push(d[i]);
        @(negedge axi_clk);
        n_checks++;
        if (o_msi_info_rdy !== 1'b0 || o_fifo_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL full: rdy=%b cnt=%0d want 0/4",
                     o_msi_info_rdy, o_fifo_cnt);
        end
        push(d[5]);
        wait_idle();
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d left want 0", expq.size());
        end
    endtask

    task automatic test_wrap();
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 25)) @(posedge axi_clk);
            #1;
            push(W'($urandom));
        end
        wait_idle();
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain: %0d left want 0", expq.size());
        end
    endtask

    task automatic test_simul();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = W'($urandom);
        wait_idle();
        push(a);
        push(b);
        @(negedge axi_clk);
        n_checks++;
        if (o_fifo_cnt !== 3'd1 || o_msi_info_vld !== 1'b1 || o_msi_info !== a) begin
            n_fail++;
            $display("FAIL simul: cnt=%0d vld=%b info=%h want 1/1/%h",
                     o_fifo_cnt, o_msi_info_vld, o_msi_info, a);
        end
        wait_idle();
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL simul_drain: %0d left want 0", expq.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        wait_idle();
        push(12'h111);
        push(12'h222);
        push(12'h333);
        @(posedge axi_clk);
        #1;
        @(negedge axi_clk);
        n_checks++;
        if (o_msi_info_vld !== 1'b1 || o_fifo_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset: vld=%b cnt=%0d want 1/2",
                     o_msi_info_vld, o_fifo_cnt);
        end
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b1;
        @(negedge axi_clk);
        n_checks++;
        if (o_msi_info_rdy !== 1'b0 || o_msi_info_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL in_reset: rdy=%b vld=%b want 0/1",
                     o_msi_info_rdy, o_msi_info_vld);
        end
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        @(negedge axi_clk);
        n_checks++;
        if (o_msi_info_vld !== 1'b0 || o_msi_info !== '0 || o_fifo_cnt !== 3'd0 ||
            o_msi_info_rdy !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: vld=%b info=%h cnt=%0d rdy=%b busy=%b",
                     o_msi_info_vld, o_msi_info, o_fifo_cnt, o_msi_info_rdy, o_busy);
        end
        repeat (40) begin
            @(negedge axi_clk);
            if (o_msi_info_vld) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL no_resume: pulse seen after reset want none");
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic test_min();
        logic [W-1:0] d[3];
        for (int i = 0; i < 3; i++) d[i] = W'($urandom);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                @(posedge axi_clk);
                #1;
            end
            m_vld = (k < 3);
            if (k < 3) m_info = d[k];
            @(negedge axi_clk);
            if (k == 1) begin
                n_checks++;
                if (m_cnt !== 3'd1 || m_out_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL min_c1: cnt=%0d vld=%b want 1/0", m_cnt, m_out_vld);
                end
            end
            if (k >= 2) begin
                n_checks++;
                if (m_out_vld !== (k == 2 || k == 5 || k == 8) ||
                    m_out !== d[(k - 2) / 3]) begin
                    n_fail++;
                    $display("FAIL min_c%0d: vld=%b info=%h want %b/%h", k,
                             m_out_vld, m_out, (k == 2 || k == 5 || k == 8),
                             d[(k - 2) / 3]);
                end
            end
        end
        @(posedge axi_clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_simul();
        test_reset_mid();
        test_min();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imsic_msi_sender.md
Name: imsic_msi_sender

Overview:
- Bus-clock-domain stage directly upstream of the IMSIC async receive stage.
- Queues decoded MSI writes (hart, interrupt file, source ID) from the bus slave decode.
- Replays each queued MSI as a wide level pulse on `o_msi_info_vld`, with `o_msi_info` held stable, so the receiver can capture it by synchronising `o_msi_info_vld` and detecting its falling edge.
- Owns the timing guarantees (pulse width, data hold, inter-message gap) that make the crossing safe.

Parameters:
- NR_INTP_FILES, 7, number of interrupt files per hart (m, s, vs).
- NR_HARTS, 1, number of harts.
- NR_SRC, 256, interrupt identities per file.
- FIFO_DEPTH, 4, MSI queue entries; power of 2, ≥2.
- VLD_HIGH_CYCLES, 8, `axi_clk` cycles that `o_msi_info_vld` stays high; ≥1.
- INFO_HOLD_CYCLES, 8, `axi_clk` cycles that `o_msi_info` stays frozen after `o_msi_info_vld` falls, before the next message may start; ≥1.
- localparam MSI_INFO_WIDTH = NR_HARTS_WIDTH + $clog2(NR_INTP_FILES) + $clog2(NR_SRC), where NR_HARTS_WIDTH = 1 if NR_HARTS==1, else $clog2(NR_HARTS).

Ports:
- axi_clk  input  1  sole clock.
- axi_rst  input  1  synchronous, active-high reset.
- i_msi_info  input  MSI_INFO_WIDTH  decoded MSI {hart, file, source ID}.
- i_msi_info_vld  input  1  request valid.
- o_msi_info_rdy  output  1  queue can accept; transfer occurs when `i_msi_info_vld` & `o_msi_info_rdy`.
- o_msi_info  output  MSI_INFO_WIDTH  registered MSI toward the receiver.
- o_msi_info_vld  output  1  registered level pulse toward the receiver.
- o_fifo_cnt  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
- o_busy  output  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Clock and reset: one clock, `axi_clk`. Reset `axi_rst` is synchronous and active-high.
- Reset values: `o_msi_info`=0, `o_msi_info_vld`=0, `o_fifo_cnt`=0, `o_busy`=0, FIFO pointers=0, state=IDLE, counter=0.
- `o_msi_info_rdy` = ~axi_rst & (fifo_cnt != FIFO_DEPTH). It is combinational and does not depend on `i_msi_info_vld`.
- Push: on a handshake, write to `mem[wr_ptr]` and increment `wr_ptr`, wrapping modulo FIFO_DEPTH.
- Pop: occurs in IDLE when the FIFO is non-empty. Increment `rd_ptr` with wrap.
- Count update: push-only +1; pop-only −1; push and pop in the same cycle leave the count unchanged.
- Full: no push, even if a pop occurs in the same cycle (`rdy` is already 0).
- FSM IDLE:
  - If count != 0: `o_msi_info` <= `mem[rd_ptr]`; `o_msi_info_vld` <= 1; `cnt` <= VLD_HIGH_CYCLES−1; go to HIGH.
  - Otherwise stay in IDLE.
- FSM HIGH:
  - If `cnt`==0: `o_msi_info_vld` <= 0; `cnt` <= INFO_HOLD_CYCLES−1; go to LOW.
  - Otherwise `cnt`−−.
- FSM LOW:
  - If `cnt`==0: go to IDLE.
  - Otherwise `cnt`−−.
- `o_msi_info` changes only on an IDLE pop. It is stable throughout HIGH, LOW, and any idle period.
- Pulse timing: `o_msi_info_vld` is high for exactly VLD_HIGH_CYCLES cycles. It is low for at least INFO_HOLD_CYCLES+1 cycles between consecutive pulses.
- Throughput: one MSI per VLD_HIGH_CYCLES+INFO_HOLD_CYCLES+1 cycles.
- Latency: handshake at cycle t into an empty queue with FSM in IDLE gives count=1 at t+1. `o_msi_info` is valid and `o_msi_info_vld`=1 at t+2.
- Integration requirement (parameter sizing):
  - VLD_HIGH_CYCLES must span ≥2 `csr_clk` periods.
  - INFO_HOLD_CYCLES must span ≥6 `csr_clk` periods: 3-flop sync, 1 delay stage, capture, plus margin.
- Reset mid-operation: the state returns to IDLE and `o_msi_info_vld` drops in the next cycle. Queued entries are discarded. No partial pulse resumes.
- Ordering: strict FIFO order with no coalescing. Duplicate MSIs are each delivered.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Fullness is derived from the count only.

Test Plan:
- Single MSI (defaults): push 0x0A5 at cycle 0 → `o_msi_info`=0x0A5 and `o_msi_info_vld`=1 at cycle 2. `vld` stays high through cycle 9, is low at cycle 10, and `o_busy` returns to 0 at cycle 18.
- Backpressure: push 6 MSIs back-to-back with FIFO_DEPTH=4 → `rdy` drops once count=4 after the first pop. All 6 emerge in order, with exactly 8 high cycles and ≥9 low cycles each.
- Wrap-around: stream 10 messages with randomly gapped pushes → output order matches input order; `o_fifo_cnt` never exceeds 4 and never underflows.
- Simultaneous push/pop: at count=1 in IDLE, push while a pop occurs → count stays 1; the pushed entry is emitted next.
- Reset mid-HIGH: assert `axi_rst` for 1 cycle during the 4th high cycle with 2 entries queued → the next cycle shows `vld`=0, `o_msi_info`=0, count=0, `rdy`=1; no further pulses.
- Minimum parameters (VLD_HIGH_CYCLES=1, INFO_HOLD_CYCLES=1): 3 queued MSIs → `vld` high 1 cycle, low 2 cycles, repeating; info is stable across each pulse and its following low gap.
